// File: rtl/conv_spk_packer.sv
// Spike-frame packer: collects per-lane spike bits into row-major frames,
// commits them lane by lane into a frame memory indexed by time step and
// channel, and serves one-cycle-latency reads to the next layer.
module conv_spk_packer #(
    parameter int TIME_STEPS         = 10,
    parameter int OUTPUT_CHANNELS    = 32,
    parameter int EC_SIZE            = 4,
    parameter int OUTPUT_FRAME_WIDTH = 26,
    parameter int OUTPUT_FRAME_SIZE  = OUTPUT_FRAME_WIDTH * OUTPUT_FRAME_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en_activ,
    input  logic [EC_SIZE-1:0]                   spk_out,
    input  logic [$clog2(OUTPUT_CHANNELS)+2-1:0] oc_phase,
    input  logic [$clog2(TIME_STEPS)+2-1:0]      curr_time_step,
    input  logic                                 layer_done,
    input  logic                                 spk_in_ram_en,
    input  logic [$clog2(OUTPUT_CHANNELS)+2-1:0] ic,
    input  logic [$clog2(TIME_STEPS)+2-1:0]      time_step,
    input  logic                                 frames_consumed,
    output logic [OUTPUT_FRAME_SIZE-1:0]         spk_in_train,
    output logic                                 pre_syn_RAM_loaded,
    output logic                                 overrun_err
);

    localparam int CW    = $clog2(OUTPUT_CHANNELS) + 2;
    localparam int TW    = $clog2(TIME_STEPS) + 2;
    localparam int DEPTH = TIME_STEPS * OUTPUT_CHANNELS;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW    = $clog2(OUTPUT_FRAME_SIZE + 1);
    localparam int SW    = (OUTPUT_FRAME_SIZE > 1) ? $clog2(OUTPUT_FRAME_SIZE) : 1;
    localparam int LW    = (EC_SIZE > 1) ? $clog2(EC_SIZE) : 1;

    typedef enum logic [1:0] {StIdle, StCollect, StCommit, StReady} state_e;

    state_e                 state_q, state_d;
    logic [NW-1:0]          n_q, n_d;
    logic [LW-1:0]          lane_q, lane_d;
    logic [CW-1:0]          oc_q, oc_d;
    logic [TW-1:0]          ts_q, ts_d;
    logic                   pend_q, pend_d;
    logic                   err_q, err_d;
    logic [OUTPUT_FRAME_SIZE-1:0] stage_q [EC_SIZE];
    logic [OUTPUT_FRAME_SIZE-1:0] mem_q [DEPTH];
    logic [OUTPUT_FRAME_SIZE-1:0] rd_q;

    logic          sample_we;
    logic          stage_clr;
    logic          close;
    logic          mem_we;
    logic [IW-1:0] mem_idx;
    logic [IW-1:0] rd_idx;
    logic          rd_in_range;
    int            ch;

    // Next-state logic for the write FSM, staging control and commit address
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        lane_d    = lane_q;
        oc_d      = oc_q;
        ts_d      = ts_q;
        pend_d    = pend_q;
        err_d     = err_q;
        sample_we = 1'b0;
        stage_clr = 1'b0;
        close     = 1'b0;
        mem_we    = 1'b0;
        mem_idx   = '0;
        ch        = int'(oc_q) * EC_SIZE + int'(lane_q);

        unique case (state_q)
            StIdle: begin
                if (en_activ) begin
                    sample_we = 1'b1;
                    n_d       = n_q + NW'(1);
                    pend_d    = pend_q | layer_done;
                    state_d   = StCollect;
                    close     = (int'(n_q) + 1 == OUTPUT_FRAME_SIZE);
                end else if (layer_done || pend_q) begin
                    pend_d  = 1'b0;
                    state_d = StReady;
                end
            end
            StCollect: begin
                pend_d = pend_q | layer_done;
                if (en_activ) begin
                    sample_we = 1'b1;
                    n_d       = n_q + NW'(1);
                    close     = (int'(n_q) + 1 == OUTPUT_FRAME_SIZE);
                end else begin
                    // en_activ fell mid-frame: n>0 is implied by being in COLLECT
                    close = 1'b1;
                end
            end
            StCommit: begin
                pend_d = pend_q | layer_done;
                if (en_activ) err_d = 1'b1;
                if (ch < OUTPUT_CHANNELS && int'(ts_q) < TIME_STEPS) begin
                    mem_we  = 1'b1;
                    mem_idx = IW'(int'(ts_q) * OUTPUT_CHANNELS + ch);
                end
                if (int'(lane_q) == EC_SIZE - 1) begin
                    stage_clr = 1'b1;
                    n_d       = '0;
                    lane_d    = '0;
                    state_d   = StIdle;
                end else begin
                    lane_d = lane_q + LW'(1);
                end
            end
            StReady: begin
                if (en_activ) err_d = 1'b1;
                if (frames_consumed) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (close) begin
            oc_d    = oc_phase;
            ts_d    = curr_time_step;
            lane_d  = '0;
            state_d = StCommit;
        end
    end

    // FSM and control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            n_q     <= '0;
            lane_q  <= '0;
            oc_q    <= '0;
            ts_q    <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            lane_q  <= lane_d;
            oc_q    <= oc_d;
            ts_q    <= ts_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    // Staging frames: one bit per neuron per lane, cleared after each commit
    always_ff @(posedge clk) begin
        if (rst || stage_clr) begin
            for (int l = 0; l < EC_SIZE; l++) stage_q[l] <= '0;
        end else if (sample_we) begin
            for (int l = 0; l < EC_SIZE; l++) stage_q[l][n_q[SW-1:0]] <= spk_out[l];
        end
    end

    // Frame memory is not reset; a commit always overwrites a whole frame
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem_q[mem_idx] <= stage_q[lane_q];
    end

    always_comb begin
        rd_in_range = (int'(ic) < OUTPUT_CHANNELS) && (int'(time_step) < TIME_STEPS);
        rd_idx      = IW'(int'(time_step) * OUTPUT_CHANNELS + int'(ic));
    end

    // Registered read port; sees pre-commit contents on a same-cycle collision
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else if (spk_in_ram_en) begin
            rd_q <= rd_in_range ? mem_q[rd_idx] : '0;
        end
    end

    assign spk_in_train       = rd_q;
    assign pre_syn_RAM_loaded = (state_q == StReady);
    assign overrun_err        = err_q;

endmodule

// File: doc/conv_spk_packer.md
CONV_SPK_PACKER -- requirements
Module: conv_spk_packer

Interface
REQ-001 Parameters SHALL be: TIME_STEPS, default 10, number of time steps; OUTPUT_CHANNELS, default 32, output channels; EC_SIZE, default 4, parallel neuron lanes; OUTPUT_FRAME_WIDTH, default 26, frame width; OUTPUT_FRAME_SIZE, default OUTPUT_FRAME_WIDTH*OUTPUT_FRAME_WIDTH, bits per frame.
REQ-002 One clock and one reset: reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 en_activ  input  1  one neuron per lane is being activated this cycle.
REQ-006 spk_out  input  EC_SIZE  spike bit per lane for the current neuron.
REQ-007 oc_phase  input  $clog2(OUTPUT_CHANNELS)+2  output-channel group of the current activation pass.
REQ-008 curr_time_step  input  $clog2(TIME_STEPS)+2  time step of the current activation pass.
REQ-009 layer_done  input  1  one-cycle pulse: producer has finished the whole layer.
REQ-010 spk_in_ram_en  input  1  read request from the next-layer event controller.
REQ-011 ic  input  $clog2(OUTPUT_CHANNELS)+2  read channel index.
REQ-012 time_step  input  $clog2(TIME_STEPS)+2  read time-step index.
REQ-013 frames_consumed  input  1  one-cycle pulse: consumer has finished reading.
REQ-014 spk_in_train  output  OUTPUT_FRAME_SIZE  registered read data.
REQ-015 pre_syn_RAM_loaded  output  1  level: all frames stored and readable.
REQ-016 overrun_err  output  1  sticky error flag.

Function
REQ-017 The block SHALL store TIME_STEPS*OUTPUT_CHANNELS frames at index time_step*OUTPUT_CHANNELS+channel.
REQ-018 Write FSM states SHALL be IDLE, COLLECT, COMMIT, READY.
REQ-019 IDLE: en_activ=1 -> COLLECT; the neuron counter captures that cycle's sample as neuron 0.
REQ-020 COLLECT: each en_activ=1 cycle SHALL write spk_out[l] into lane-l staging bit n and increment n; bit n is row-major neuron y*OUTPUT_FRAME_WIDTH+x.
REQ-021 The frame SHALL close when n reaches OUTPUT_FRAME_SIZE, or when en_activ falls with n>0; unwritten bits SHALL be 0.
REQ-022 On close: latch oc_phase and curr_time_step; next state COMMIT.
REQ-023 COMMIT SHALL write one lane per cycle, lanes 0..EC_SIZE-1, to channel oc_phase*EC_SIZE+l; it SHALL skip lanes with channel >= OUTPUT_CHANNELS; it SHALL then clear staging and return to IDLE.
REQ-024 en_activ=1 during COMMIT or READY SHALL drop the sample and set overrun_err.
REQ-025 layer_done in IDLE -> READY next cycle; in COLLECT/COMMIT it SHALL be held pending and take effect on return to IDLE.
REQ-026 READY: pre_syn_RAM_loaded=1; frames_consumed -> IDLE with pre_syn_RAM_loaded=0 on the next cycle.
REQ-027 Read: spk_in_ram_en=1 in cycle t SHALL give spk_in_train = frame[time_step*OUTPUT_CHANNELS+ic] in cycle t+1 (one-cycle latency); otherwise spk_in_train holds.
REQ-028 Out-of-range ic or time_step SHALL return all zeros.
REQ-029 Reads SHALL be served in any state; data is guaranteed coherent only while pre_syn_RAM_loaded=1.
REQ-030 Simultaneous read and commit to the same index SHALL return the old contents.

Reset
REQ-031 rst SHALL force: state IDLE; counter 0; staging 0; pending layer_done cleared; pre_syn_RAM_loaded=0; overrun_err=0; spk_in_train=0.
REQ-032 Frame memory SHALL NOT be cleared by rst; every commit overwrites a whole frame.
REQ-033 rst mid-COLLECT or mid-COMMIT SHALL discard the partial frame with no memory write.

Verification
REQ-034 Defaults; oc_phase=0, curr_time_step=0; 676 en_activ cycles with spk_out=4'b0001 only at n=5 -> read ic=0,time_step=0 gives bit5=1, others 0; ic=1..3 return 0.
REQ-035 OUTPUT_CHANNELS=6, EC_SIZE=4, oc_phase=1; full pass with spk_out=4'b1111 -> channels 4,5 are all ones; channels 6,7 are not written; a read with ic=6 returns 0.
REQ-036 en_activ drops after 675 neurons -> frame commits, bit 675=0; en_activ=1 in the first COMMIT cycle -> overrun_err=1 until rst.
REQ-037 layer_done pulsed mid-COLLECT -> pre_syn_RAM_loaded rises only after COMMIT finishes; frames_consumed -> 0 next cycle.
REQ-038 Assert rst at n=300 -> no write; readback of that frame is unchanged; all outputs at reset values the following cycle.
